dm_cache_controller: RTL

Direct-mapped, write-through, no-write-allocate cache controller between the CPU load/store port and the word-addressed data memory (15-bit word address, 4-word burst read, single-word synchronous write). Holds tag/valid/data arrays internally. Sequences line fills on read misses and forwards every store to memory. One outstanding CPU request at a time.

---
 rtl/dm_cache_controller.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/dm_cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller with 4-word line fills.
// Define CACHE_STATS_EN to add the stat_hits/stat_misses counter outputs.
module dm_cache_controller #(
    parameter int ADDR_W      = 15,
    parameter int DATA_W      = 32,
    parameter int INDEX_W     = 10,
    parameter int MEM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    output logic              cpu_ready,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_hit,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata0,
    input  logic [DATA_W-1:0] mem_rdata1,
    input  logic [DATA_W-1:0] mem_rdata2,
    input  logic [DATA_W-1:0] mem_rdata3
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses
`endif
);

    localparam int TAG_W = ADDR_W - INDEX_W - 2;
    localparam int LINES = 1 << INDEX_W;
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOOKUP = 2'd1;
    localparam logic [1:0] S_FILL   = 2'd2;
    localparam logic [1:0] S_WRITE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              miss_q, miss_d;
    logic              hit_q, hit_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LINES-1:0]  valid_q, valid_d;

    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [DATA_W-1:0] data_mem [LINES][4];

    logic [INDEX_W-1:0] idx;
    logic [1:0]         off;
    logic [TAG_W-1:0]   tag;
    logic               lookup_hit;
    logic               fill_done;
    logic               wr_hit;

    assign idx        = addr_q[INDEX_W+1:2];
    assign off        = addr_q[1:0];
    assign tag        = addr_q[ADDR_W-1:INDEX_W+2];
    assign lookup_hit = valid_q[idx] && (tag_mem[idx] == tag);
    assign fill_done  = (state_q == S_FILL) && (cnt_q == '0);
    assign wr_hit     = (state_q == S_WRITE) && hit_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        miss_d  = miss_q;
        hit_d   = hit_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    addr_d  = cpu_addr;
                    we_d    = cpu_we;
                    wdata_d = cpu_wdata;
                    miss_d  = 1'b0;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (we_q) begin
                    hit_d   = lookup_hit;
                    state_d = S_WRITE;
                end else if (lookup_hit) begin
                    state_d = S_IDLE;
                end else begin
                    miss_d  = 1'b1;
                    cnt_d   = CNT_W'(MEM_LATENCY - 1);
                    state_d = S_FILL;
                end
            end
            S_FILL: begin
                // The refill returns to LOOKUP so the load completes through the normal hit path.
                if (cnt_q == '0) begin
                    valid_d[idx] = 1'b1;
                    state_d      = S_LOOKUP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cpu_ready = (state_q == S_IDLE);
        cpu_done  = 1'b0;
        cpu_rdata = '0;
        cpu_hit   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            S_LOOKUP: begin
                if (!we_q && lookup_hit) begin
                    cpu_done  = 1'b1;
                    cpu_rdata = data_mem[idx][off];
                    cpu_hit   = !miss_q;
                end
            end
            S_FILL: begin
                mem_read = 1'b1;
                mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
            end
            S_WRITE: begin
                mem_write = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                cpu_done  = 1'b1;
                cpu_hit   = hit_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            miss_q  <= 1'b0;
            hit_q   <= 1'b0;
            cnt_q   <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            miss_q  <= miss_d;
            hit_q   <= hit_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    // Arrays are not reset; an async reset forces IDLE so an in-flight fill or write never lands.
    always_ff @(posedge clk) begin
        if (fill_done) begin
            tag_mem[idx]     <= tag;
            data_mem[idx][0] <= mem_rdata0;
            data_mem[idx][1] <= mem_rdata1;
            data_mem[idx][2] <= mem_rdata2;
            data_mem[idx][3] <= mem_rdata3;
        end else if (wr_hit) begin
            data_mem[idx][off] <= wdata_q;
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] stat_hits_q, stat_hits_d;
    logic [31:0] stat_misses_q, stat_misses_d;

    // Only the first lookup of a request counts; the post-fill lookup has miss_q set.
    always_comb begin
        stat_hits_d   = stat_hits_q;
        stat_misses_d = stat_misses_q;
        if (state_q == S_LOOKUP && !miss_q) begin
            if (lookup_hit) stat_hits_d = stat_hits_q + 32'd1;
            else            stat_misses_d = stat_misses_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_hits_q   <= '0;
            stat_misses_q <= '0;
        end else begin
            stat_hits_q   <= stat_hits_d;
            stat_misses_q <= stat_misses_d;
        end
    end

    assign stat_hits   = stat_hits_q;
    assign stat_misses = stat_misses_q;
`endif

endmodule
